// File: rtl/rvfi_pkg.sv
// Shared types and helpers for the RVFI retirement tracker.
// - rvfi_slot_t : per-instruction metadata carried through the shadow pipeline
// - rvfi_pkt_t  : registered RVFI packet fields, excluding order, mode, ixl and halt
// - MT_*        : Sodor memory-type encodings
// - mem_mask()  : byte-lane mask from a memory type and the low address bits
package rvfi_pkg;

  // Width of the data fields stored in the slots. The tracker's XLEN must match it.
  localparam int unsigned SlotXlen = 32;
  localparam int unsigned MaskW    = SlotXlen / 8;

  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  localparam logic [1:0] RvfiModeM = 2'b11;
  localparam logic [1:0] RvfiIxl32 = 2'b01;

  typedef struct packed {
    logic                valid;
    logic [31:0]         insn;
    logic [SlotXlen-1:0] pc;
    logic [SlotXlen-1:0] rs1_rdata;
    logic [SlotXlen-1:0] rs2_rdata;
    logic [SlotXlen-1:0] mem_addr;
    logic [SlotXlen-1:0] mem_wdata;
    logic [MaskW-1:0]    mem_rmask;
    logic [MaskW-1:0]    mem_wmask;
  } rvfi_slot_t;

  typedef struct packed {
    logic                valid;
    logic [31:0]         insn;
    logic                trap;
    logic                intr;
    logic [4:0]          rs1_addr;
    logic [4:0]          rs2_addr;
    logic [SlotXlen-1:0] rs1_rdata;
    logic [SlotXlen-1:0] rs2_rdata;
    logic [4:0]          rd_addr;
    logic [SlotXlen-1:0] rd_wdata;
    logic [SlotXlen-1:0] pc_rdata;
    logic [SlotXlen-1:0] pc_wdata;
    logic [SlotXlen-1:0] mem_addr;
    logic [MaskW-1:0]    mem_rmask;
    logic [MaskW-1:0]    mem_wmask;
    logic [SlotXlen-1:0] mem_rdata;
    logic [SlotXlen-1:0] mem_wdata;
  } rvfi_pkt_t;

  // Byte lanes touched by an access. Unknown types touch nothing.
  function automatic logic [MaskW-1:0] mem_mask(logic [2:0] typ, logic [1:0] addr);
    logic [MaskW-1:0] m;
    m = '0;
    unique case (typ)
      MT_B, MT_BU: m = 4'b0001 << addr;
      MT_H, MT_HU: m = 4'b0011 << {addr[1], 1'b0};
      MT_W:        m = 4'b1111;
      default:     m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rvfi_slot_reg.sv
// One shadow-pipeline slot.
// - clock, reset  : clock and synchronous active-high reset (slot becomes invalid)
// - advance_i     : pipeline moves this cycle; load slot_i
// - kill_in_i     : the incoming instruction is squashed while loading
// - kill_hold_i   : invalidate the held instruction when not advancing
// - slot_i        : content presented by the previous stage
// - slot_o        : current slot content
module rvfi_slot_reg
  import rvfi_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       advance_i,
  input  logic       kill_in_i,
  input  logic       kill_hold_i,
  input  rvfi_slot_t slot_i,
  output rvfi_slot_t slot_o
);

  rvfi_slot_t slot_d, slot_q;

  always_comb begin
    slot_d = slot_q;
    if (advance_i) begin
      slot_d       = slot_i;
      slot_d.valid = slot_i.valid & ~kill_in_i;
    end else if (kill_hold_i) begin
      slot_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/rvfi_retire_tracker.sv
// RVFI retirement monitor that shadows a Sodor pipeline of DEPTH stages.
// Inputs : clock/reset (sync, active-high); issue_* capture into slot 0; stall_i freezes
//          all slots; kill_mask_i squashes slots; mem_* sampled at slot MEM_STAGE;
//          wb_* and mem_rdata_i sampled when slot DEPTH-1 retires.
// Outputs: rvfi_* single-channel packet, registered, valid for one cycle per retirement.
module rvfi_retire_tracker
  import rvfi_pkg::*;
#(
  parameter int unsigned XLEN      = 32,  // must equal rvfi_pkg::SlotXlen
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned MEM_STAGE = 1,
  parameter int unsigned ORDER_W   = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               issue_valid_i,
  input  logic [31:0]        issue_insn_i,
  input  logic [XLEN-1:0]    issue_pc_i,
  input  logic [XLEN-1:0]    issue_rs1_rdata_i,
  input  logic [XLEN-1:0]    issue_rs2_rdata_i,
  input  logic               stall_i,
  input  logic [DEPTH-1:0]   kill_mask_i,
  input  logic               mem_req_i,
  input  logic               mem_we_i,
  input  logic [2:0]         mem_typ_i,
  input  logic [XLEN-1:0]    mem_addr_i,
  input  logic [XLEN-1:0]    mem_wdata_i,
  input  logic [XLEN-1:0]    mem_rdata_i,
  input  logic [4:0]         wb_rd_addr_i,
  input  logic               wb_rd_wen_i,
  input  logic [XLEN-1:0]    wb_rd_wdata_i,
  input  logic [XLEN-1:0]    wb_next_pc_i,
  input  logic               wb_trap_i,
  output logic               rvfi_valid_o,
  output logic [ORDER_W-1:0] rvfi_order_o,
  output logic [31:0]        rvfi_insn_o,
  output logic               rvfi_trap_o,
  output logic               rvfi_halt_o,
  output logic               rvfi_intr_o,
  output logic [1:0]         rvfi_mode_o,
  output logic [1:0]         rvfi_ixl_o,
  output logic [4:0]         rvfi_rs1_addr_o,
  output logic [4:0]         rvfi_rs2_addr_o,
  output logic [XLEN-1:0]    rvfi_rs1_rdata_o,
  output logic [XLEN-1:0]    rvfi_rs2_rdata_o,
  output logic [4:0]         rvfi_rd_addr_o,
  output logic [XLEN-1:0]    rvfi_rd_wdata_o,
  output logic [XLEN-1:0]    rvfi_pc_rdata_o,
  output logic [XLEN-1:0]    rvfi_pc_wdata_o,
  output logic [XLEN-1:0]    rvfi_mem_addr_o,
  output logic [XLEN/8-1:0]  rvfi_mem_rmask_o,
  output logic [XLEN/8-1:0]  rvfi_mem_wmask_o,
  output logic [XLEN-1:0]    rvfi_mem_rdata_o,
  output logic [XLEN-1:0]    rvfi_mem_wdata_o
);

  rvfi_slot_t slot_q   [DEPTH];
  // slot_out is what each slot hands downstream: at MEM_STAGE it carries the live
  // memory request, so the capture travels with the instruction as it advances.
  rvfi_slot_t slot_out [DEPTH];
  rvfi_slot_t issue_slot;
  rvfi_slot_t mem_slot;
  logic [MaskW-1:0] mem_bmask;

  always_comb begin
    issue_slot           = '0;
    issue_slot.valid     = issue_valid_i;
    issue_slot.insn      = issue_insn_i;
    issue_slot.pc        = issue_pc_i;
    issue_slot.rs1_rdata = issue_rs1_rdata_i;
    issue_slot.rs2_rdata = issue_rs2_rdata_i;
  end

  assign mem_bmask = mem_req_i ? mem_mask(mem_typ_i, mem_addr_i[1:0]) : '0;

  always_comb begin
    mem_slot           = slot_q[MEM_STAGE];
    mem_slot.mem_addr  = mem_addr_i;
    mem_slot.mem_wdata = mem_wdata_i;
    mem_slot.mem_rmask = mem_we_i ? '0 : mem_bmask;
    mem_slot.mem_wmask = mem_we_i ? mem_bmask : '0;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    rvfi_slot_t slot_in;
    logic       kill_in;

    if (i == 0) begin : g_head
      // Issue is never squashed on entry.
      assign slot_in = issue_slot;
      assign kill_in = 1'b0;
    end else begin : g_body
      assign slot_in = slot_out[i-1];
      assign kill_in = kill_mask_i[i-1];
    end

    if (i == MEM_STAGE) begin : g_mem
      assign slot_out[i] = mem_slot;
    end else begin : g_pass
      assign slot_out[i] = slot_q[i];
    end

    rvfi_slot_reg u_slot (
      .clock       (clock),
      .reset       (reset),
      .advance_i   (~stall_i),
      .kill_in_i   (kill_in),
      .kill_hold_i (kill_mask_i[i]),
      .slot_i      (slot_in),
      .slot_o      (slot_q[i])
    );
  end

  rvfi_slot_t         ret_slot;
  logic               retire;
  logic [4:0]         rd_addr;
  rvfi_pkt_t          pkt_d, pkt_q;
  logic [ORDER_W-1:0] order_d, order_q;
  logic [ORDER_W-1:0] rvfi_order_d, rvfi_order_q;
  logic               intr_pending_d, intr_pending_q;

  assign ret_slot = slot_out[DEPTH-1];
  assign retire   = ret_slot.valid & ~stall_i & ~kill_mask_i[DEPTH-1];
  assign rd_addr  = wb_rd_wen_i ? wb_rd_addr_i : 5'd0;

  always_comb begin
    pkt_d          = pkt_q;
    pkt_d.valid    = 1'b0;
    order_d        = order_q;
    rvfi_order_d   = rvfi_order_q;
    intr_pending_d = intr_pending_q;
    if (retire) begin
      pkt_d.valid     = 1'b1;
      pkt_d.insn      = ret_slot.insn;
      pkt_d.trap      = wb_trap_i;
      pkt_d.intr      = intr_pending_q;
      pkt_d.rs1_addr  = ret_slot.insn[19:15];
      pkt_d.rs2_addr  = ret_slot.insn[24:20];
      pkt_d.rs1_rdata = ret_slot.rs1_rdata;
      pkt_d.rs2_rdata = ret_slot.rs2_rdata;
      pkt_d.rd_addr   = rd_addr;
      pkt_d.rd_wdata  = (rd_addr == 5'd0) ? '0 : wb_rd_wdata_i;
      pkt_d.pc_rdata  = ret_slot.pc;
      pkt_d.pc_wdata  = wb_next_pc_i;
      pkt_d.mem_addr  = ret_slot.mem_addr;
      pkt_d.mem_rmask = ret_slot.mem_rmask;
      pkt_d.mem_wmask = ret_slot.mem_wmask;
      pkt_d.mem_rdata = mem_rdata_i;
      pkt_d.mem_wdata = ret_slot.mem_wdata;
      rvfi_order_d    = order_q;
      order_d         = order_q + ORDER_W'(1);
      // A trap marks the following retirement as the handler entry; any other
      // retirement consumes the pending flag.
      intr_pending_d  = wb_trap_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_q          <= '0;
      order_q        <= '0;
      rvfi_order_q   <= '0;
      intr_pending_q <= 1'b0;
    end else begin
      pkt_q          <= pkt_d;
      order_q        <= order_d;
      rvfi_order_q   <= rvfi_order_d;
      intr_pending_q <= intr_pending_d;
    end
  end

  assign rvfi_valid_o     = pkt_q.valid;
  assign rvfi_order_o     = rvfi_order_q;
  assign rvfi_insn_o      = pkt_q.insn;
  assign rvfi_trap_o      = pkt_q.trap;
  assign rvfi_halt_o      = 1'b0;
  assign rvfi_intr_o      = pkt_q.intr;
  assign rvfi_mode_o      = RvfiModeM;
  assign rvfi_ixl_o       = RvfiIxl32;
  assign rvfi_rs1_addr_o  = pkt_q.rs1_addr;
  assign rvfi_rs2_addr_o  = pkt_q.rs2_addr;
  assign rvfi_rs1_rdata_o = pkt_q.rs1_rdata;
  assign rvfi_rs2_rdata_o = pkt_q.rs2_rdata;
  assign rvfi_rd_addr_o   = pkt_q.rd_addr;
  assign rvfi_rd_wdata_o  = pkt_q.rd_wdata;
  assign rvfi_pc_rdata_o  = pkt_q.pc_rdata;
  assign rvfi_pc_wdata_o  = pkt_q.pc_wdata;
  assign rvfi_mem_addr_o  = pkt_q.mem_addr;
  assign rvfi_mem_rmask_o = pkt_q.mem_rmask;
  assign rvfi_mem_wmask_o = pkt_q.mem_wmask;
  assign rvfi_mem_rdata_o = pkt_q.mem_rdata;
  assign rvfi_mem_wdata_o = pkt_q.mem_wdata;

endmodule
